// File: rtl/pdua_control_unit.sv
// Moore sequencer for the PDUA datapath: fetch/decode/execute microcycles drive the control word.
// Control outputs are registered from the next-state decode, so they are a pure function of the state.
module pdua_control_unit #(
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = ADDR_WIDTH'(7)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            out_IR,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  wr_rdn,
  output logic                  enaf,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic                  bank_wr_en,
  output logic [ADDR_WIDTH-1:0] BusB_addr,
  output logic [ADDR_WIDTH-1:0] BusC_addr,
  output logic                  sclr,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  halted,
  output logic                  fetch
);

  typedef enum logic [4:0] {
    S_CLR, S_F0, S_F1, S_F2, S_DEC, S_O0, S_O1, S_PCI,
    S_XLDI, S_XADDI, S_XNOTA, S_S0, S_S1, S_S2, S_J, S_BR, S_HALT
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_STA  = 5'b00011;
  localparam logic [4:0] OP_JMP  = 5'b00100;
  localparam logic [4:0] OP_JZ   = 5'b00101;
  localparam logic [4:0] OP_JN   = 5'b00110;
  localparam logic [4:0] OP_NOTA = 5'b00111;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_PASS_B = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_INC_B  = 3'b011;
  localparam logic [2:0] ALU_NOT_B  = 3'b110;

  typedef struct packed {
    logic                  wr_rdn;
    logic                  enaf;
    logic [2:0]            selop;
    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] busb;
    logic [ADDR_WIDTH-1:0] busc;
    logic                  sclr;
    logic                  ir_en;
    logic                  mar_en;
    logic                  mdr_en;
    logic                  mdr_alu_n;
    logic                  halted;
    logic                  fetch;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl;

  // Only Z and N steer branches; C and P are part of the flag bundle but unused here.
  logic unused_flags;
  assign unused_flags = C | P;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_CLR: c.sclr = 1'b1;
      S_F0, S_O0: begin
        c.busb   = PC_ADDR;
        c.selop  = ALU_PASS_B;
        c.mar_en = 1'b1;
        c.fetch  = (s == S_F0);
      end
      S_F1, S_O1: begin
        c.mdr_en    = 1'b1;
        c.mdr_alu_n = 1'b1;
      end
      S_F2, S_PCI: begin
        c.ir_en      = (s == S_F2);
        c.busb       = PC_ADDR;
        c.busc       = PC_ADDR;
        c.selop      = ALU_INC_B;
        c.bank_wr_en = 1'b1;
      end
      S_XLDI: begin
        c.selop      = ALU_PASS_A;
        c.busc       = ACC_ADDR;
        c.bank_wr_en = 1'b1;
        c.enaf       = 1'b1;
      end
      S_XADDI: begin
        c.selop      = ALU_ADD;
        c.busb       = ACC_ADDR;
        c.busc       = ACC_ADDR;
        c.bank_wr_en = 1'b1;
        c.enaf       = 1'b1;
      end
      S_XNOTA: begin
        c.selop      = ALU_NOT_B;
        c.busb       = ACC_ADDR;
        c.busc       = ACC_ADDR;
        c.bank_wr_en = 1'b1;
        c.enaf       = 1'b1;
      end
      S_S0: begin
        c.selop  = ALU_PASS_A;
        c.mar_en = 1'b1;
      end
      S_S1: begin
        c.busb   = ACC_ADDR;
        c.selop  = ALU_PASS_B;
        c.mdr_en = 1'b1;
      end
      S_S2: c.wr_rdn = 1'b1;
      S_J: begin
        c.selop      = ALU_PASS_A;
        c.busc       = PC_ADDR;
        c.bank_wr_en = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // IR is only reloaded in F2, so out_IR is stable for the whole execute phase.
  always_comb begin
    nxt = state;
    case (state)
      S_CLR: nxt = S_F0;
      S_F0:  nxt = S_F1;
      S_F1:  nxt = S_F2;
      S_F2:  nxt = S_DEC;
      S_DEC: begin
        case (out_IR)
          OP_NOP:  nxt = S_F0;
          OP_LDI, OP_ADDI, OP_STA, OP_JMP, OP_JZ, OP_JN: nxt = S_O0;
          OP_NOTA: nxt = S_XNOTA;
          OP_HALT: nxt = S_HALT;
          default: nxt = S_F0;
        endcase
      end
      S_O0: nxt = S_O1;
      S_O1: begin
        case (out_IR)
          OP_LDI:       nxt = S_XLDI;
          OP_ADDI:      nxt = S_XADDI;
          OP_STA:       nxt = S_S0;
          OP_JMP:       nxt = S_J;
          OP_JZ, OP_JN: nxt = S_BR;
          default:      nxt = S_F0;
        endcase
      end
      S_XLDI, S_XADDI: nxt = S_PCI;
      S_XNOTA:         nxt = S_F0;
      S_S0:            nxt = S_S1;
      S_S1:            nxt = S_S2;
      S_S2:            nxt = S_PCI;
      S_PCI:           nxt = S_F0;
      S_J:             nxt = S_F0;
      S_BR:            nxt = ((out_IR == OP_JZ) ? Z : N) ? S_J : S_PCI;
      S_HALT:          nxt = S_HALT;
      default:         nxt = S_CLR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLR;
      ctl   <= decode(S_CLR);
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
    end
  end

  assign wr_rdn     = ctl.wr_rdn;
  assign enaf       = ctl.enaf;
  assign selop      = ctl.selop;
  assign shamt      = 2'b00;
  assign bank_wr_en = ctl.bank_wr_en;
  assign BusB_addr  = ctl.busb;
  assign BusC_addr  = ctl.busc;
  assign sclr       = ctl.sclr;
  assign ir_en      = ctl.ir_en;
  assign mar_en     = ctl.mar_en;
  assign mdr_en     = ctl.mdr_en;
  assign mdr_alu_n  = ctl.mdr_alu_n;
  assign halted     = ctl.halted;
  assign fetch      = ctl.fetch;

endmodule

// File: doc/pdua_control_unit.md
# pdua_control_unit

- Sequencing controller for the PDUA datapath. It drives the datapath's control word: the ALU, register bank, IR/MAR/MDR enables and the memory read/write strobe.
- It consumes the IR opcode and the ALU flags.
- It implements a Moore FSM with fetch, decode and execute microcycles per instruction.
- It replaces the hand-driven control vectors used for datapath bring-up. It sits beside the PDUA datapath at the CPU top level.

## Interface
Parameters:
- ADDR_WIDTH, 3, register-bank address width
- PC_ADDR, 3'd0, bank address of program counter
- ACC_ADDR, 3'd7, bank address of accumulator

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- out_IR  in  5  opcode from datapath IR
- C, N, P, Z  in  1 each  registered ALU flags from datapath
- wr_rdn  out  1  memory strobe: 1 write mem[MAR]<=MDR, 0 read
- enaf  out  1  flag register update enable
- selop  out  3  ALU op; operand A = MDR, operand B = bank[BusB_addr]. Encoding: 000 PASS_A, 001 PASS_B, 010 ADD, 011 INC_B, 100 AND, 101 OR, 110 NOT_B, 111 SHIFT
- shamt  out  2  shift amount, held 00 by this block
- bank_wr_en  out  1  bank[BusC_addr] <= ALU result
- BusB_addr, BusC_addr  out  ADDR_WIDTH  bank read/write addresses
- sclr  out  1  synchronous clear of IR/MAR/MDR
- ir_en  out  1  IR <= MDR
- mar_en  out  1  MAR <= ALU result
- mdr_en  out  1  MDR load enable
- mdr_alu_n  out  1  MDR source: 1 memory data, 0 ALU result
- halted  out  1  high while in HALT
- fetch  out  1  one-cycle pulse in F0 (instruction boundary)

## Operation
- Outputs are a pure decode of the state register. Unlisted outputs in any state are 0/000.
- Flags are sampled only on branch-decision transitions.
- States:
  - CLR: sclr=1.
  - F0: BusB=PC, PASS_B, mar_en.
  - F1: wr_rdn=0, mdr_en, mdr_alu_n=1.
  - F2: ir_en, BusB=BusC=PC, INC_B, bank_wr_en.
  - DEC: no outputs; branches on out_IR.
- Operand fetch, shared by all two-byte ops:
  - O0 = F0 outputs.
  - O1 = F1 outputs.
  - PCI: PC++ with F2 outputs, but ir_en=0.
- Opcodes:
  - 00000 NOP: DEC -> F0.
  - 00001 LDI imm: O0, O1, then X: PASS_A, BusC=ACC, bank_wr_en, enaf. Then PCI -> F0.
  - 00010 ADDI imm: O0, O1, then X: ADD, BusB=BusC=ACC, bank_wr_en, enaf. Then PCI -> F0.
  - 00011 STA addr:
    - O0, O1.
    - S0: PASS_A, mar_en.
    - S1: BusB=ACC, PASS_B, mdr_en, mdr_alu_n=0.
    - S2: wr_rdn=1.
    - PCI -> F0.
  - 00100 JMP addr: O0, O1, then J: PASS_A, BusC=PC, bank_wr_en -> F0.
  - 00101 JZ / 00110 JN addr: O0, O1, then BR.
    - BR has no outputs. It samples Z (JZ) or N (JN).
    - Flag=1 -> J -> F0. Flag=0 -> PCI -> F0.
  - 00111 NOTA: X: BusB=BusC=ACC, NOT_B, bank_wr_en, enaf -> F0.
  - 11111 HALT: -> HALT. HALT outputs all 0 with halted=1. HALT is exited only by rst.
  - All other opcodes are executed as NOP.
- enaf is asserted only in the LDI, ADDI and NOTA X states. Fetch, PC increment and address moves never alter flags.

## Timing
- Reset (async assert):
  - State goes to CLR immediately.
  - Outputs: sclr=1, all others 0, halted=0, fetch=0.
- After rst deassert: first rising edge CLR -> F0.
- Memory is synchronous, single cycle. Data is valid into MDR on the edge ending F1/O1. The write occurs on the edge ending S2.
- Cycle counts, F0 to next F0, including F0/F1/F2/DEC:
  - NOP / undefined opcode: 4
  - NOTA: 5
  - JMP: 7
  - LDI, ADDI: 8
  - JZ/JN taken: 8
  - JZ/JN not taken: 8
  - STA: 10
- Branch flag is the value present at the clock edge leaving BR. This reflects the last enaf write.
- rst asserted mid-instruction: the instruction is abandoned; state goes to CLR, no further writes, bank contents untouched by this block.
- PC wrap: INC_B at PC=8'hFF yields 8'h00. This is datapath arithmetic; the controller takes no special action.
- fetch is high exactly one cycle per instruction. It never pulses in HALT or CLR.

## Test plan
- Reset: hold rst 2 cycles, release.
  - During rst: sclr=1, all other outputs 0.
  - Then 1 cycle CLR, then F0 with mar_en=1, BusB_addr=0, selop=001.
- NOP stream (opcode 00000 repeated): fetch pulses every 4 cycles; bank_wr_en=1 only in F2 with BusC_addr=0, selop=011.
- LDI 0x00 then JZ: LDI asserts enaf once in X (selop=000, BusC_addr=7). With Z=1, JZ goes to J (BusC_addr=0, selop=000). Repeat with Z=0: PCI path taken; 8 cycles either way.
- STA: cycle-exact sequence F0,F1,F2,DEC,O0,O1,S0,S1,S2,PCI. wr_rdn=1 only in S2; mdr_alu_n=0 in S1 with BusB_addr=7.
- Opcode 11111: halted=1 from cycle 5 onward, all enables 0 for 20+ cycles. Assert rst: halted=0, returns to CLR.
- Reset mid-STA: assert rst during S1. Outputs go to reset values asynchronously; no wr_rdn=1 is ever observed.
